// File: rtl/cpu_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// cpu_trace_buffer_if : trace FIFO drain port (valid/ready head-entry read)
// Revision: 1.0
// ============================================================================
interface cpu_trace_buffer_if;
    logic        RdValid;
    logic        RdReady;
    logic [31:0] RdPC;
    logic [31:0] RdInst;
    logic [31:0] RdR;

    modport master (
        output RdValid,
        output RdPC,
        output RdInst,
        output RdR,
        input  RdReady
    );

    modport slave (
        input  RdValid,
        input  RdPC,
        input  RdInst,
        input  RdR,
        output RdReady
    );
endinterface
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// cpu_trace_buffer : triggered capture of CPU PC/Inst/R into a FWFT FIFO
// Revision: 1.0
// ============================================================================
module cpu_trace_buffer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int SKIP_NOP = 1,
    parameter int LEN_W    = 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [31:0]             PC,
    input  logic [31:0]             Inst,
    input  logic [31:0]             R,
    input  logic                    Arm,
    input  logic                    Abort,
    input  logic [31:0]             TrigPC,
    input  logic [LEN_W-1:0]        CaptLen,
    cpu_trace_buffer_if.master      rd,
    output logic [ADDR_W:0]         Count,
    output logic [LEN_W-1:0]        Captured,
    output logic [15:0]             Dropped,
    output logic [1:0]              State
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam logic [ADDR_W:0]  C_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [LEN_W-1:0] C_CAP_MAX = '1;
    localparam logic [15:0]      C_DRP_MAX = 16'hFFFF;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    captured_q, captured_d;
    logic [15:0]         dropped_q, dropped_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [95:0]         mem_q [DEPTH];

    logic                w_recordable;
    logic                w_attempt;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_valid;
    logic [95:0]         w_head;

    assign w_recordable = (SKIP_NOP == 0) || (Inst != 32'h0000_0000);
    assign w_valid      = (count_q != '0);
    assign w_pop        = w_valid && rd.RdReady;

    // Window control: Abort beats Arm, and Arm only restarts an idle or finished window.
    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        w_attempt  = 1'b0;
        if (Abort) begin
            state_d = ST_IDLE;
        end else if (Arm && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d    = ST_ARMED;
            captured_d = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (PC == TrigPC) begin
                        state_d   = ST_CAPTURE;
                        w_attempt = w_recordable;
                    end
                end
                ST_CAPTURE: w_attempt = w_recordable;
                default: ;
            endcase
            if (w_attempt) begin
                captured_d = (captured_q == C_CAP_MAX) ? captured_q : captured_q + 1'b1;
                if (CaptLen != '0 && captured_d == CaptLen) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    // A pop in the same cycle frees a slot, so a full FIFO can still accept the attempt.
    assign w_push = w_attempt && ((count_q != C_FULL) || w_pop);
    assign w_drop = w_attempt && !w_push;

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dropped_d = dropped_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_drop && dropped_q != C_DRP_MAX) begin
            dropped_d = dropped_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            captured_q <= '0;
            dropped_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            dropped_q  <= dropped_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge Clk) begin
        if (Rst_n && w_push) begin
            mem_q[wr_ptr_q] <= {PC, Inst, R};
        end
    end

    assign w_head     = mem_q[rd_ptr_q];
    assign rd.RdValid = w_valid;
    assign rd.RdPC    = w_valid ? w_head[95:64] : 32'h0000_0000;
    assign rd.RdInst  = w_valid ? w_head[63:32] : 32'h0000_0000;
    assign rd.RdR     = w_valid ? w_head[31:0]  : 32'h0000_0000;

    assign Count    = count_q;
    assign Captured = captured_q;
    assign Dropped  = dropped_q;
    assign State    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_cpu_trace_buffer : directed stimulus with a queue scoreboard for drained entries
// Revision: 1.0
// ============================================================================
module tb_cpu_trace_buffer;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] PC, Inst, R, TrigPC;
    logic        Arm, Abort;
    logic [7:0]  CaptLen;
    logic [4:0]  Count;
    logic [7:0]  Captured;
    logic [15:0] Dropped;
    logic [1:0]  State;

    cpu_trace_buffer_if rd ();

    cpu_trace_buffer #(
        .DEPTH    (16),
        .ADDR_W   (4),
        .SKIP_NOP (1),
        .LEN_W    (8)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .PC       (PC),
        .Inst     (Inst),
        .R        (R),
        .Arm      (Arm),
        .Abort    (Abort),
        .TrigPC   (TrigPC),
        .CaptLen  (CaptLen),
        .rd       (rd),
        .Count    (Count),
        .Captured (Captured),
        .Dropped  (Dropped),
        .State    (State)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] r;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One CPU cycle; rec says whether this cycle must land in the FIFO.
    task automatic step(input logic [31:0] pc, input logic [31:0] inst, input bit rec);
        ent_t e;
        PC   = pc;
        Inst = inst;
        R    = pc + 32'h0000_1000;
        if (rec) begin
            e.pc   = pc;
            e.inst = inst;
            e.r    = pc + 32'h0000_1000;
            exp_q.push_back(e);
        end
        @(posedge Clk);
        #1;
        Arm   = 1'b0;
        Abort = 1'b0;
    endtask

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge Clk) begin
        if (Rst_n && rd.RdValid && rd.RdReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got pc 0x%08h expected no entry", rd.RdPC);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_pc",   rd.RdPC,   e.pc);
                chk("pop_inst", rd.RdInst, e.inst);
                chk("pop_r",    rd.RdR,    e.r);
            end
        end
    end

    function automatic logic [31:0] nz(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    initial begin
        Rst_n      = 1'b0;
        Arm        = 1'b1;
        Abort      = 1'b0;
        PC         = 32'h0000_000C;
        Inst       = 32'hDEAD_BEEF;
        R          = 32'h1234_5678;
        TrigPC     = 32'h0000_000C;
        CaptLen    = 8'd1;
        rd.RdReady = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_state",    32'(State),      32'd0);
        chk("rst_count",    32'(Count),      32'd0);
        chk("rst_valid",    32'(rd.RdValid), 32'd0);
        chk("rst_rdpc",     rd.RdPC,         32'd0);
        chk("rst_dropped",  32'(Dropped),    32'd0);
        chk("rst_captured", 32'(Captured),   32'd0);

        // Trigger at PC=C, window of 3
        Rst_n      = 1'b1;
        Arm        = 1'b0;
        rd.RdReady = 1'b0;
        TrigPC     = 32'h0000_000C;
        CaptLen    = 8'd3;
        Arm = 1'b1;
        step(32'h0, nz(32'h0), 1'b0);
        chk("arm_state", 32'(State), 32'd1);
        step(32'h4, nz(32'h4), 1'b0);
        step(32'h8, nz(32'h8), 1'b0);
        chk("armed_wait", 32'(State), 32'd1);
        step(32'hC, nz(32'hC), 1'b1);
        chk("trig_state", 32'(State),    32'd2);
        chk("trig_count", 32'(Count),    32'd1);
        chk("trig_head",  rd.RdPC,       32'hC);
        step(32'h10, nz(32'h10), 1'b1);
        step(32'h14, nz(32'h14), 1'b1);
        chk("win_state",    32'(State),    32'd3);
        chk("win_count",    32'(Count),    32'd3);
        chk("win_captured", 32'(Captured), 32'd3);
        step(32'h18, nz(32'h18), 1'b0);
        chk("done_count", 32'(Count), 32'd3);

        // Drain the three entries
        rd.RdReady = 1'b1;
        for (int i = 0; i < 3; i++) step(32'h1C + 32'(4*i), nz(32'h1C), 1'b0);
        chk("drain_valid", 32'(rd.RdValid), 32'd0);
        chk("drain_count", 32'(Count),      32'd0);
        chk("drain_rdpc",  rd.RdPC,         32'd0);
        rd.RdReady = 1'b0;

        // Overflow: 20 attempts into 16 slots
        TrigPC  = 32'h0000_0100;
        CaptLen = 8'd0;
        Arm     = 1'b1;
        step(32'h0F0, nz(32'h0F0), 1'b0);
        chk("rearm_state",    32'(State),    32'd1);
        chk("rearm_captured", 32'(Captured), 32'd0);
        for (int i = 0; i < 20; i++) step(32'h100 + 32'(4*i), nz(32'h100 + 32'(4*i)), i < 16);
        chk("ovf_count",    32'(Count),    32'd16);
        chk("ovf_dropped",  32'(Dropped),  32'd4);
        chk("ovf_captured", 32'(Captured), 32'd20);
        chk("ovf_head",     rd.RdPC,       32'h100);
        chk("ovf_state",    32'(State),    32'd2);

        // Full FIFO with concurrent pop accepts the new tail
        rd.RdReady = 1'b1;
        step(32'h150, nz(32'h150), 1'b1);
        rd.RdReady = 1'b0;
        chk("fullpop_count",    32'(Count),    32'd16);
        chk("fullpop_dropped",  32'(Dropped),  32'd4);
        chk("fullpop_captured", 32'(Captured), 32'd21);
        chk("fullpop_head",     rd.RdPC,       32'h104);

        // Abort keeps contents and records nothing that cycle
        Abort = 1'b1;
        step(32'h154, nz(32'h154), 1'b0);
        chk("abort_state",   32'(State),   32'd0);
        chk("abort_count",   32'(Count),   32'd16);
        chk("abort_dropped", 32'(Dropped), 32'd4);

        rd.RdReady = 1'b1;
        for (int i = 0; i < 16; i++) step(32'h160 + 32'(4*i), nz(32'h160), 1'b0);
        rd.RdReady = 1'b0;
        chk("drain2_count", 32'(Count), 32'd0);

        // NOP skipping inside a window, then Abort and re-Arm
        TrigPC = 32'h0000_0200;
        Arm    = 1'b1;
        step(32'h1F0, nz(32'h1F0), 1'b0);
        chk("nop_arm_captured", 32'(Captured), 32'd0);
        step(32'h200, nz(32'h200), 1'b1);
        step(32'h204, 32'h0,       1'b0);
        step(32'h208, nz(32'h208), 1'b1);
        step(32'h20C, 32'h0,       1'b0);
        step(32'h210, nz(32'h210), 1'b1);
        chk("nop_captured", 32'(Captured), 32'd3);
        chk("nop_count",    32'(Count),    32'd3);
        chk("nop_state",    32'(State),    32'd2);
        Abort = 1'b1;
        step(32'h214, nz(32'h214), 1'b0);
        chk("nop_abort_state", 32'(State), 32'd0);
        chk("nop_abort_count", 32'(Count), 32'd3);
        Arm = 1'b1;
        step(32'h218, nz(32'h218), 1'b0);
        chk("rearm2_state",    32'(State),    32'd1);
        chk("rearm2_captured", 32'(Captured), 32'd0);
        Abort = 1'b1;
        step(32'h21C, nz(32'h21C), 1'b0);
        rd.RdReady = 1'b1;
        for (int i = 0; i < 3; i++) step(32'h220, nz(32'h220), 1'b0);
        rd.RdReady = 1'b0;
        chk("drain3_count", 32'(Count), 32'd0);

        // CaptLen=1: trigger cycle goes straight to DONE
        TrigPC  = 32'h0000_0300;
        CaptLen = 8'd1;
        Arm     = 1'b1;
        step(32'h2FC, nz(32'h2FC), 1'b0);
        step(32'h300, nz(32'h300), 1'b1);
        chk("len1_state",    32'(State),    32'd3);
        chk("len1_captured", 32'(Captured), 32'd1);
        step(32'h304, nz(32'h304), 1'b0);
        chk("len1_count", 32'(Count), 32'd1);
        rd.RdReady = 1'b1;
        step(32'h308, nz(32'h308), 1'b0);
        rd.RdReady = 1'b0;
        chk("len1_drained", 32'(Count), 32'd0);
        chk("end_dropped",  32'(Dropped), 32'd4);
        chk("sb_empty",     32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
